// File: rtl/uart_word_arbiter.sv
// uart_word_arbiter
//   Shares one uart_tx among NUM_REQ word-sized requesters. A granted word is
//   latched, then sent MSB-byte first over the uart_tx handshake. Grants are
//   made per word, so bytes from different requesters never interleave.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   req_valid_i  per-requester word pending (held until its ready pulse)
//   req_data_i   requester i occupies slice i (WORD_SIZE_BY*PAYLOAD_BITS wide)
//   req_ready_o  one-cycle accept pulse, one-hot
//   grant_o      one-hot owner of the word in flight, 0 when idle
//   tx_en_o      one-cycle start pulse to uart_tx
//   tx_data_o    byte to uart_tx, stable while tx_en_o is high
//   tx_busy_i    uart_tx busy
//   busy_o       high whenever the FSM is not idle
//
// Configuration
//   UART_ARB_FIXED_PRIORITY_EN: lowest-index valid requester always wins and
//   the round-robin pointer is held at 0. Undefined: round-robin.
module uart_word_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned WORD_SIZE_BY = 4,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  input  logic [NUM_REQ*WORD_SIZE_BY*PAYLOAD_BITS-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                       req_ready_o,
  output logic [NUM_REQ-1:0]                       grant_o,
  output logic                                     tx_en_o,
  output logic [PAYLOAD_BITS-1:0]                  tx_data_o,
  input  logic                                     tx_busy_i,
  output logic                                     busy_o
);

  localparam int unsigned WordBits = WORD_SIZE_BY * PAYLOAD_BITS;
  localparam int unsigned CntW     = (WORD_SIZE_BY > 1) ? $clog2(WORD_SIZE_BY) : 1;
  localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WORD_SIZE_BY - 1);

  typedef enum logic [1:0] {StIdle, StSend, StWaitAck, StWaitDone} state_e;

  state_e                r_state;
  logic [WordBits-1:0]   r_shift;
  logic [CntW-1:0]       r_cnt;
  logic [PtrW-1:0]       r_ptr;
  logic [PtrW-1:0]       r_owner;
  logic [NUM_REQ-1:0]    r_ready;
  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_tx_en;
  logic [PAYLOAD_BITS-1:0] r_tx_data;
  logic                  r_busy;

  logic [NUM_REQ-1:0]    w_rot;
  logic                  w_found;
  logic [PtrW-1:0]       w_win;
  logic [NUM_REQ-1:0]    w_onehot;

  // Rotate valids so bit 0 is the requester at the pointer, then take the
  // first set bit. With the pointer held at 0 this is plain fixed priority.
  always_comb begin
    w_rot   = NUM_REQ'({req_valid_i, req_valid_i} >> r_ptr);
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_win   = PtrW'((32'(r_ptr) + k) % NUM_REQ);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_onehot[i] = (32'(w_win) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_ready   <= '0;
      r_grant   <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_ready <= '0;
      r_tx_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_shift <= req_data_i[32'(w_win)*WordBits +: WordBits];
            r_ready <= w_onehot;
            r_grant <= w_onehot;
            r_owner <= w_win;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StSend;
          end
        end
        StSend: begin
          if (!tx_busy_i) begin
            r_tx_en   <= 1'b1;
            r_tx_data <= r_shift[WordBits-1 -: PAYLOAD_BITS];
            r_state   <= StWaitAck;
          end
        end
        StWaitAck: begin
          // Busy may rise any cycle after the start pulse; wait for it so the
          // previous byte's idle level is never mistaken for completion.
          if (tx_busy_i) r_state <= StWaitDone;
        end
        StWaitDone: begin
          if (!tx_busy_i) begin
            if (r_cnt == LastCnt) begin
              r_grant <= '0;
              r_busy  <= 1'b0;
`ifdef UART_ARB_FIXED_PRIORITY_EN
              r_ptr   <= '0;
`else
              r_ptr   <= (32'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;
`endif
              r_state <= StIdle;
            end else begin
              r_shift <= r_shift << PAYLOAD_BITS;
              r_cnt   <= r_cnt + 1'b1;
              r_state <= StSend;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign grant_o     = r_grant;
  assign tx_en_o     = r_tx_en;
  assign tx_data_o   = r_tx_data;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_word_arbiter.sv
// Bench for uart_word_arbiter: a 2-requester/4-byte instance driven from a
// vector table plus hand sequences, and a 3-requester/1-byte instance for
// byte-sized words. A simple uart_tx model holds busy for a fixed time.
module tb_uart_word_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Main instance: NUM_REQ=2, WORD_SIZE_BY=4
  logic [1:0]  req_valid = '0;
  logic [63:0] req_data  = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        busy;
  logic        force_busy = 1'b0;
  int          busy_cnt = 0;

  uart_word_arbiter #(.NUM_REQ(2), .WORD_SIZE_BY(4), .PAYLOAD_BITS(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .tx_en_o     (tx_en),
    .tx_data_o   (tx_data),
    .tx_busy_i   (tx_busy),
    .busy_o      (busy)
  );

  // Byte-sized instance: NUM_REQ=3, WORD_SIZE_BY=1
  logic [2:0]  b_valid = '0;
  logic [23:0] b_data  = '0;
  logic [2:0]  b_ready;
  logic [2:0]  b_grant;
  logic        b_en;
  logic [7:0]  b_txd;
  logic        b_txbusy;
  logic        b_busy;
  int          b_cnt = 0;

  uart_word_arbiter #(.NUM_REQ(3), .WORD_SIZE_BY(1), .PAYLOAD_BITS(8)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (b_valid),
    .req_data_i  (b_data),
    .req_ready_o (b_ready),
    .grant_o     (b_grant),
    .tx_en_o     (b_en),
    .tx_data_o   (b_txd),
    .tx_busy_i   (b_txbusy),
    .busy_o      (b_busy)
  );

  // uart_tx models: busy rises the cycle after the start pulse
  assign tx_busy  = force_busy || (busy_cnt != 0);
  assign b_txbusy = (b_cnt != 0);

  always @(posedge clk) begin
    if (tx_en === 1'b1) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (b_en === 1'b1) b_cnt <= 3;
    else if (b_cnt != 0) b_cnt <= b_cnt - 1;
  end

  function automatic int idx_of(input logic [2:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < 3; i++) if (v[i] === 1'b1) begin r = i; c++; end
    return (c == 1) ? r : -1;
  endfunction

  // Monitors: cumulative logs, only ever written here
  logic [7:0] log_byte[$];
  int         log_own[$];
  logic [7:0] b_log_byte[$];
  int         b_log_own[$];
  int         ready_cnt = 0;
  int         ready_idx = -1;
  int         grant_err = 0;
  int         en_busy_err = 0;
  logic       prev_busy = 1'b0;

  always @(posedge clk) begin
    if (tx_en === 1'b1) begin
      log_byte.push_back(tx_data);
      log_own.push_back(idx_of({1'b0, grant}));
      if (prev_busy) en_busy_err <= en_busy_err + 1;
    end
    if (req_ready !== 2'b00 && !rst) begin
      ready_cnt <= ready_cnt + 1;
      ready_idx <= idx_of({1'b0, req_ready});
    end
    if (busy === 1'b1 && !$onehot(grant)) grant_err <= grant_err + 1;
    if (busy === 1'b0 && grant !== 2'b00) grant_err <= grant_err + 1;
    prev_busy <= tx_busy;
    if (b_en === 1'b1) begin
      b_log_byte.push_back(b_txd);
      b_log_own.push_back(idx_of(b_grant));
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input logic level, input int limit, input string name);
    int n = 0;
    while (busy !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, busy}, {63'd0, level});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] word_at(input int base);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      w = w << 8;
      if (base + i < log_byte.size()) w[7:0] = log_byte[base + i];
    end
    return w;
  endfunction

  function automatic int own_at(input int base);
    int o = -2;
    for (int i = 0; i < 4; i++) begin
      if (base + i >= log_own.size()) return -3;
      if (i == 0) o = log_own[base];
      else if (log_own[base + i] != o) return -4;
    end
    return o;
  endfunction

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] d0;
    logic [31:0] d1;
    int          exp_own;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vt[5];
  int   exp_ord[4];
  int   b_exp_ord[4];
  logic [7:0] b_exp_byte[4];

  initial begin
    int base;
    int rbase;
    int n;
    int en_seen;

    // Round-robin pointer carries across vectors
    vt[0] = '{2'b01, 32'h7700006A, 32'h0,        0, 32'h7700006A};
`ifdef UART_ARB_FIXED_PRIORITY_EN
    vt[1] = '{2'b11, 32'h11111111, 32'h22222222, 0, 32'h11111111};
`else
    vt[1] = '{2'b11, 32'h11111111, 32'h22222222, 1, 32'h22222222};
`endif
    vt[2] = '{2'b11, 32'h33333333, 32'h44444444, 0, 32'h33333333};
    vt[3] = '{2'b10, 32'h0,        32'h55555555, 1, 32'h55555555};
    vt[4] = '{2'b11, 32'h66666666, 32'h77777777, 0, 32'h66666666};
`ifdef UART_ARB_FIXED_PRIORITY_EN
    exp_ord   = '{0, 0, 0, 0};
    b_exp_ord = '{0, 0, 0, 0};
`else
    exp_ord   = '{0, 1, 0, 1};
    b_exp_ord = '{0, 1, 2, 0};
`endif

    // Reset state, sampled while rst is held
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {39'd0, req_ready, grant, tx_en, tx_data, busy, b_ready, b_grant,
                            b_en, b_txd, b_busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven words
    for (int v = 0; v < 5; v++) begin
      base  = log_byte.size();
      rbase = ready_cnt;
      @(negedge clk);
      req_valid = vt[v].valid;
      req_data  = {vt[v].d1, vt[v].d0};
      wait_busy(1'b1, 20, "accept");
      req_valid = '0;
      wait_busy(1'b0, 400, "word done");
      @(negedge clk);
      check($sformatf("vec%0d byte count", v), 64'(log_byte.size() - base), 64'd4);
      check($sformatf("vec%0d word", v), {32'd0, word_at(base)}, {32'd0, vt[v].exp_word});
      check($sformatf("vec%0d owner", v), 64'(own_at(base)), 64'(vt[v].exp_own));
      check($sformatf("vec%0d ready pulses", v), 64'(ready_cnt - rbase), 64'd1);
      check($sformatf("vec%0d ready idx", v), 64'(ready_idx), 64'(vt[v].exp_own));
    end

    // Continuous contention from reset
    do_reset();
    base  = log_byte.size();
    rbase = ready_cnt;
    req_valid = 2'b11;
    req_data  = {32'h22222222, 32'h11111111};
    n = 0;
    while (log_byte.size() < base + 16 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    req_valid = '0;
    wait_busy(1'b0, 400, "contention done");
    @(negedge clk);
    check("contention bytes", 64'(log_byte.size() - base), 64'd16);
    check("contention readies", 64'(ready_cnt - rbase), 64'd4);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("contention word%0d owner", w), 64'(own_at(base + 4*w)), 64'(exp_ord[w]));
      check($sformatf("contention word%0d data", w), {32'd0, word_at(base + 4*w)},
            (exp_ord[w] == 0) ? 64'h11111111 : 64'h22222222);
    end

    // Busy held high at grant
    do_reset();
    force_busy = 1'b1;
    base = log_byte.size();
    req_valid = 2'b01;
    req_data  = {32'h0, 32'hCAFEF00D};
    wait_busy(1'b1, 20, "held accept");
    req_valid = '0;
    en_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_en !== 1'b0) en_seen++;
    end
    check("held no tx_en", 64'(en_seen), 64'd0);
    check("held grant", {62'd0, grant}, 64'd1);
    force_busy = 1'b0;
    @(posedge clk);
    #1;
    check("release tx_en", {63'd0, tx_en}, 64'd1);
    check("release tx_data", {56'd0, tx_data}, 64'hCA);
    @(posedge clk);
    #1;
    check("release single pulse", {63'd0, tx_en}, 64'd0);
    wait_busy(1'b0, 400, "held done");
    @(negedge clk);
    check("held word", {32'd0, word_at(base)}, 64'hCAFEF00D);
    check("held byte count", 64'(log_byte.size() - base), 64'd4);

    // Reset in the middle of a word
    do_reset();
    base = log_byte.size();
    req_valid = 2'b01;
    req_data  = {32'h0, 32'hA1B2C3D4};
    n = 0;
    while (log_byte.size() < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midword first bytes", (log_byte.size() >= base + 2) ?
          {48'd0, log_byte[base], log_byte[base+1]} : 64'd0, 64'hA1B2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midword reset outputs", {49'd0, req_ready, grant, tx_en, tx_data, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    base = log_byte.size();
    wait_busy(1'b1, 20, "resend accept");
    req_valid = '0;
    wait_busy(1'b0, 400, "resend done");
    @(negedge clk);
    check("resend byte count", 64'(log_byte.size() - base), 64'd4);
    check("resend word", {32'd0, word_at(base)}, 64'hA1B2C3D4);

    // Byte-sized words, three requesters
    b_exp_byte = '{8'hA0, 8'hB1, 8'hC2, 8'hA0};
    base = b_log_byte.size();
    b_data  = {8'hC2, 8'hB1, 8'hA0};
    b_valid = 3'b111;
    n = 0;
    while (b_log_byte.size() < base + 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    b_valid = '0;
    repeat (20) @(negedge clk);
    check("bytes mode count", 64'(b_log_byte.size() - base), 64'd4);
    check("bytes mode idle", {63'd0, b_busy}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (base + i < b_log_own.size()) begin
        check($sformatf("bytes mode owner%0d", i), 64'(b_log_own[base + i]), 64'(b_exp_ord[i]));
        check($sformatf("bytes mode data%0d", i), {56'd0, b_log_byte[base + i]},
              {56'd0, b_exp_byte[b_exp_ord[i]]});
      end
    end

    // Whole-run invariants
    check("grant one-hot", 64'(grant_err), 64'd0);
    check("tx_en after busy", 64'(en_busy_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
